// File: rtl/fei4_rx_mux.sv
// Round-robin merge of NCH FE-I4 receiver data FIFOs into one tagged 32-bit stream,
// with per-channel error counters and a word counter on the 8-bit register bus.

module fei4_err_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       strobe,
   output logic [7:0] cnt
);
   // A clear wins over a coincident strobe, so the counter reads 0 afterwards.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= 8'd0;
      else if (strobe && cnt != 8'hFF)
         cnt <= cnt + 8'd1;
   end
endmodule

module fei4_rx_mux #(
   parameter int unsigned NCH       = 4,
   parameter logic [3:0]  ID_PREFIX = 4'h0
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST,
   input  logic [NCH-1:0]      CH_FIFO_EMPTY,
   input  logic [24*NCH-1:0]   CH_FIFO_DATA,
   output logic [NCH-1:0]      CH_FIFO_READ,
   input  logic [NCH-1:0]      CH_RX_READY,
   input  logic [NCH-1:0]      CH_ERR_STROBE,
   input  logic                FIFO_READ,
   output logic                FIFO_EMPTY,
   output logic [31:0]         FIFO_DATA,
   input  logic [15:0]         BUS_ADD,
   input  logic [7:0]          BUS_DATA_IN,
   output logic [7:0]          BUS_DATA_OUT,
   input  logic                BUS_WR,
   input  logic                BUS_RD
);

   logic                 soft_rst, rst_all;
   logic [NCH-1:0]       en_mask;
   logic                 arb_en;
   logic [NCH-1:0]       cand;
   logic [7:0]           cand8;
   logic [3:0]           sum;
   logic [2:0]           ptr, gnt, ptr_nxt;
   logic                 gnt_vld, take, pop;
   logic [7:0][23:0]     dat8;
   logic [7:0]           rd8;
   logic                 out_valid;
   logic [31:0]          out_data;
   logic [15:0]          word_cnt;
   logic [7:0]           shadow;
   logic [NCH-1:0][7:0]  err_cnt;
   logic [7:0][7:0]      err8;
   logic [7:0]           rd_mux;
   logic                 unused;

   assign soft_rst = BUS_WR && (BUS_ADD == 16'd0);
   assign rst_all  = BUS_RST | soft_rst;
   assign unused   = ^BUS_DATA_IN;

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         en_mask <= '1;
         arb_en  <= 1'b1;
      end else if (BUS_WR) begin
         if (BUS_ADD == 16'd2) en_mask <= BUS_DATA_IN[NCH-1:0];
         if (BUS_ADD == 16'd3) arb_en  <= BUS_DATA_IN[0];
      end
   end

   assign cand  = en_mask & ~CH_FIFO_EMPTY & {NCH{arb_en}};
   assign cand8 = 8'(cand);

   // First candidate at or after the pointer, wrapping modulo NCH.
   always_comb begin
      gnt     = 3'd0;
      gnt_vld = 1'b0;
      sum     = 4'd0;
      for (int i = 0; i < NCH; i++) begin
         sum = {1'b0, ptr} + 4'(i);
         if (sum >= 4'(NCH)) sum = sum - 4'(NCH);
         if (!gnt_vld && cand8[sum[2:0]]) begin
            gnt_vld = 1'b1;
            gnt     = sum[2:0];
         end
      end
   end

   always_comb begin
      dat8 = '0;
      for (int c = 0; c < NCH; c++) dat8[c] = CH_FIFO_DATA[24*c +: 24];
   end

   assign take    = ~out_valid | FIFO_READ;
   // No pop during a reset cycle: the output register is cleared, so the word would be lost.
   assign pop     = gnt_vld & take & ~rst_all;
   assign rd8     = 8'(pop) << gnt;
   assign CH_FIFO_READ = rd8[NCH-1:0];
   assign ptr_nxt = (gnt == 3'(NCH-1)) ? 3'd0 : gnt + 3'd1;

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         ptr       <= 3'd0;
         word_cnt  <= 16'd0;
      end else if (take) begin
         if (gnt_vld) begin
            out_valid <= 1'b1;
            out_data  <= {ID_PREFIX, 1'b0, gnt, dat8[gnt]};
            ptr       <= ptr_nxt;
            word_cnt  <= word_cnt + 16'd1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   assign FIFO_EMPTY = ~out_valid;
   assign FIFO_DATA  = out_data;

   for (genvar c = 0; c < NCH; c++) begin : g_err
      fei4_err_cnt u_err (
         .clk    (BUS_CLK),
         .rst    (rst_all),
         .clr    (BUS_WR && (BUS_ADD == 16'(8 + c))),
         .strobe (CH_ERR_STROBE[c]),
         .cnt    (err_cnt[c])
      );
   end

   always_comb begin
      err8 = '0;
      for (int c = 0; c < NCH; c++) err8[c] = err_cnt[c];
   end

   // Reading the low counter byte freezes the high byte for a coherent 16-bit read.
   always_ff @(posedge BUS_CLK) begin
      if (rst_all)
         shadow <= 8'd0;
      else if (BUS_RD && BUS_ADD == 16'd16)
         shadow <= word_cnt[15:8];
   end

   always_comb begin
      rd_mux = 8'd0;
      case (BUS_ADD)
         16'd1:   rd_mux = 8'(CH_RX_READY);
         16'd2:   rd_mux = 8'(en_mask);
         16'd3:   rd_mux = {7'd0, arb_en};
         16'd4:   rd_mux = {7'd0, out_valid};
         16'd16:  rd_mux = word_cnt[7:0];
         16'd17:  rd_mux = shadow;
         default: begin
            if (BUS_ADD >= 16'd8 && BUS_ADD < 16'(8 + NCH))
               rd_mux = err8[BUS_ADD[2:0]];
         end
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) BUS_DATA_OUT <= 8'd0;
      else         BUS_DATA_OUT <= rd_mux;
   end

endmodule

// File: tb/tb_fei4_rx_mux.sv
// Directed bench for fei4_rx_mux: reset, arbitration order, masking, error
// counters, word counter wrap/shadow, soft reset and ARB_EN.

module tb_fei4_rx_mux;
   localparam int NCH = 4;

   logic              BUS_CLK = 1'b0;
   logic              BUS_RST;
   logic [NCH-1:0]    CH_FIFO_EMPTY;
   logic [24*NCH-1:0] CH_FIFO_DATA;
   logic [NCH-1:0]    CH_FIFO_READ;
   logic [NCH-1:0]    CH_RX_READY;
   logic [NCH-1:0]    CH_ERR_STROBE;
   logic              FIFO_READ;
   logic              FIFO_EMPTY;
   logic [31:0]       FIFO_DATA;
   logic [15:0]       BUS_ADD;
   logic [7:0]        BUS_DATA_IN;
   logic [7:0]        BUS_DATA_OUT;
   logic              BUS_WR;
   logic              BUS_RD;

   fei4_rx_mux #(.NCH(NCH), .ID_PREFIX(4'h0)) dut (
      .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
      .CH_FIFO_EMPTY(CH_FIFO_EMPTY), .CH_FIFO_DATA(CH_FIFO_DATA),
      .CH_FIFO_READ(CH_FIFO_READ), .CH_RX_READY(CH_RX_READY),
      .CH_ERR_STROBE(CH_ERR_STROBE), .FIFO_READ(FIFO_READ),
      .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
      .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN), .BUS_DATA_OUT(BUS_DATA_OUT),
      .BUS_WR(BUS_WR), .BUS_RD(BUS_RD)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   // Channel FIFO models: initial block owns wp/mem/inf, pop process owns rp.
   logic [23:0] mem [NCH][16];
   int          wp [NCH];
   int          rp [NCH];
   logic [NCH-1:0] inf = '0;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         CH_FIFO_EMPTY[c]         = inf[c] ? 1'b0 : (wp[c] == rp[c]);
         CH_FIFO_DATA[c*24 +: 24] = inf[c] ? 24'h5A5A5A : mem[c][rp[c][3:0]];
      end
   end

   always @(posedge BUS_CLK) begin
      for (int c = 0; c < NCH; c++)
         if (CH_FIFO_READ[c] && !inf[c]) rp[c] <= rp[c] + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge BUS_CLK);
      #2;
   endtask

   task automatic push(input int c, input logic [23:0] d);
      mem[c][wp[c] % 16] = d;
      wp[c] = wp[c] + 1;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
      BUS_ADD = a; BUS_RD = 1'b1;
      cyc();
      d = BUS_DATA_OUT;
      BUS_RD = 1'b0;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
      cyc();
      BUS_WR = 1'b0;
   endtask

   function automatic logic [23:0] wd(input int c, input int k);
      return 24'hA00000 + 24'(c * 256 + k);
   endfunction

   function automatic logic [31:0] ew(input int c, input logic [23:0] d);
      return {4'h0, 1'b0, 3'(c), d};
   endfunction

   initial begin
      logic [7:0] r;
      int n;
      BUS_RST = 1'b1; CH_RX_READY = '0; CH_ERR_STROBE = '0; FIFO_READ = 1'b0;
      BUS_ADD = '0; BUS_DATA_IN = '0; BUS_WR = 1'b0; BUS_RD = 1'b0;

      // Reset and idle
      cyc(); #1;
      chk("rst_ch_read", 32'(CH_FIFO_READ), 32'h0);
      cyc();
      BUS_RST = 1'b0;
      cyc();
      chk("rst_empty", 32'(FIFO_EMPTY), 32'h1);
      chk("rst_data", FIFO_DATA, 32'h0);
      chk("rst_bus_out", 32'(BUS_DATA_OUT), 32'h0);
      bus_rd(16'd2, r); chk("rst_mask", 32'(r), 32'h0F);
      bus_rd(16'd3, r); chk("rst_arb_en", 32'(r), 32'h01);
      CH_RX_READY = 4'b1010;
      bus_rd(16'd1, r); chk("rx_ready", 32'(r), 32'h0A);
      bus_rd(16'd12, r); chk("addr12_zero", 32'(r), 32'h0);
      bus_rd(16'h20, r); chk("addr20_zero", 32'(r), 32'h0);

      // Single channel, three words
      FIFO_READ = 1'b1;
      for (int k = 0; k < 3; k++) push(2, 24'hABCDE0 + 24'(k));
      #1;
      chk("ch2_pop0", 32'(CH_FIFO_READ), 32'h4);
      chk("ch2_not_yet", 32'(FIFO_EMPTY), 32'h1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("ch2_word", FIFO_DATA, ew(2, 24'hABCDE0 + 24'(k)));
         chk("ch2_valid", 32'(FIFO_EMPTY), 32'h0);
         #1;
         chk("ch2_pop", 32'(CH_FIFO_READ), (k < 2) ? 32'h4 : 32'h0);
      end
      cyc();
      chk("ch2_drained", 32'(FIFO_EMPTY), 32'h1);
      bus_rd(16'd16, r); chk("ch2_wcnt", 32'(r), 32'h3);

      // All channels busy: strict rotation from ch0
      bus_wr(16'd0, 8'h00);
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NCH; c++) push(c, wd(c, k));
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr_word", FIFO_DATA, ew(i % 4, wd(i % 4, i / 4)));
      end
      cyc();
      chk("rr_drained", 32'(FIFO_EMPTY), 32'h1);
      bus_rd(16'd16, r); chk("rr_wcnt", 32'(r), 32'h8);

      // Mask 0x0A written while all channels busy; pointer is at ch0
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < NCH; c++) push(c, wd(c, 16 + k));
      BUS_ADD = 16'd2; BUS_DATA_IN = 8'h0A; BUS_WR = 1'b1;
      cyc();
      BUS_WR = 1'b0;
      chk("mask_pending_ch0", FIFO_DATA, ew(0, wd(0, 16)));
      for (int j = 0; j < 6; j++) begin
         cyc();
         chk("mask_word", FIFO_DATA, ew((j % 2) ? 3 : 1, wd((j % 2) ? 3 : 1, 16 + j / 2)));
      end
      cyc();
      chk("mask_idle", 32'(FIFO_EMPTY), 32'h1);
      bus_rd(16'd2, r); chk("mask_rd", 32'(r), 32'h0A);
      bus_wr(16'd2, 8'h0F);
      n = 0;
      for (int t = 0; t < 20; t++) begin
         cyc();
         if (!FIFO_EMPTY) n++;
      end
      chk("mask_restore_words", 32'(n), 32'd5);

      // Error counters
      CH_ERR_STROBE = 4'b1010;
      repeat (5) cyc();
      CH_ERR_STROBE = 4'b0010;
      repeat (295) cyc();
      CH_ERR_STROBE = 4'b0000;
      bus_rd(16'd9, r);  chk("err1_sat", 32'(r), 32'd255);
      bus_rd(16'd11, r); chk("err3_cnt", 32'(r), 32'd5);
      bus_rd(16'd8, r);  chk("err0_cnt", 32'(r), 32'd0);
      BUS_ADD = 16'd9; BUS_WR = 1'b1; CH_ERR_STROBE = 4'b0010;
      cyc();
      BUS_WR = 1'b0; CH_ERR_STROBE = 4'b0000;
      bus_rd(16'd9, r);  chk("err1_clr", 32'(r), 32'd0);
      bus_rd(16'd11, r); chk("err3_kept", 32'(r), 32'd5);

      // Word counter wrap and shadow
      bus_wr(16'd0, 8'h00);
      inf[0] = 1'b1;
      repeat (65535) cyc();
      chk("stream_word", FIFO_DATA, ew(0, 24'h5A5A5A));
      inf[0] = 1'b0;
      bus_rd(16'd16, r); chk("wcnt_lo_ffff", 32'(r), 32'hFF);
      bus_rd(16'd17, r); chk("wcnt_hi_ffff", 32'(r), 32'hFF);
      push(0, 24'h123456);
      cyc();
      chk("wrap_word", FIFO_DATA, ew(0, 24'h123456));
      bus_rd(16'd16, r); chk("wcnt_lo_wrap", 32'(r), 32'h00);
      bus_rd(16'd17, r); chk("wcnt_hi_wrap", 32'(r), 32'h00);

      // Soft reset mid-stream, then ARB_EN
      FIFO_READ = 1'b0;
      cyc();
      for (int k = 0; k < 4; k++) push(1, 24'h111110 + 24'(k));
      cyc();
      chk("sr_held", FIFO_DATA, ew(1, 24'h111110));
      FIFO_READ = 1'b1; BUS_ADD = 16'd0; BUS_WR = 1'b1;
      #1;
      chk("sr_no_pop", 32'(CH_FIFO_READ), 32'h0);
      cyc();
      BUS_WR = 1'b0;
      chk("sr_empty", 32'(FIFO_EMPTY), 32'h1);
      FIFO_READ = 1'b0;
      cyc();
      chk("sr_next", FIFO_DATA, ew(1, 24'h111111));
      bus_rd(16'd2, r); chk("sr_mask_kept", 32'(r), 32'h0F);
      bus_wr(16'd3, 8'h00);
      FIFO_READ = 1'b1;
      #1;
      chk("arb_off_no_pop", 32'(CH_FIFO_READ), 32'h0);
      chk("arb_off_held", FIFO_DATA, ew(1, 24'h111111));
      chk("arb_off_valid", 32'(FIFO_EMPTY), 32'h0);
      cyc();
      FIFO_READ = 1'b0;
      chk("arb_off_drained", 32'(FIFO_EMPTY), 32'h1);
      bus_rd(16'd3, r); chk("arb_off_rd", 32'(r), 32'h0);
      bus_rd(16'd4, r); chk("not_empty_rd", 32'(r), 32'h0);
      bus_wr(16'd3, 8'h01);
      cyc();
      chk("arb_on_word", FIFO_DATA, ew(1, 24'h111112));
      bus_rd(16'd4, r); chk("not_empty_rd1", 32'(r), 32'h1);
      FIFO_READ = 1'b1;
      cyc();
      chk("arb_on_last", FIFO_DATA, ew(1, 24'h111113));
      cyc();
      chk("final_empty", 32'(FIFO_EMPTY), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
